// File: rtl/reset_seq_pkg.sv
// Shared definitions for the staged reset sequencer: state encoding,
// the fault-counter width and its saturating increment.
package reset_seq_pkg;

  localparam int STATE_W      = 3;
  localparam int LOSS_COUNT_W = 8;

  typedef enum logic [STATE_W-1:0] {
    ST_WAIT_LOCK = 3'd0,
    ST_STABILIZE = 3'd1,
    ST_RELEASE   = 3'd2,
    ST_RUN       = 3'd3,
    ST_FAULT     = 3'd4
  } state_e;

  function automatic logic [LOSS_COUNT_W-1:0] sat_inc(input logic [LOSS_COUNT_W-1:0] v);
    return (&v) ? v : v + LOSS_COUNT_W'(1);
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// Generic two-flop bit synchronizer with asynchronous active-low clear.
module sync_2ff (
  input  logic clk_i,
  input  logic rst_n_i,
  input  logic d_i,
  output logic q_o
);

  logic meta_q;
  logic sync_q;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/reset_sequencer.sv
// Staged reset release driven by PLL lock: waits for stable lock, releases
// domain resets one by one, and drops them all again on a filtered lock loss.
module reset_sequencer
  import reset_seq_pkg::*;
#(
  parameter int LOCK_STABLE_CYCLES = 65536,
  parameter int STAGE_GAP          = 16,
  parameter int NUM_STAGES         = 3,
  parameter int LOSS_FILTER        = 4
) (
  input  logic                    clock,
  input  logic                    reset_n,
  input  logic                    locked,
  output logic [NUM_STAGES-1:0]   rst_n_out,
  output logic                    ready,
  output logic [LOSS_COUNT_W-1:0] lock_loss_count,
  output logic [STATE_W-1:0]      state
);

  localparam int STAB_W = (LOCK_STABLE_CYCLES > 1) ? $clog2(LOCK_STABLE_CYCLES) : 1;
  localparam int REL_W  = $clog2(NUM_STAGES * STAGE_GAP + 1);
  localparam int LOSS_W = $clog2(LOSS_FILTER + 1);

  localparam logic [STAB_W-1:0] STAB_LAST  = STAB_W'(LOCK_STABLE_CYCLES - 1);
  localparam logic [REL_W-1:0]  FAULT_LAST = REL_W'(STAGE_GAP - 1);
  localparam logic [LOSS_W-1:0] LOSS_LAST  = LOSS_W'(LOSS_FILTER - 1);

  logic locked_s;

  state_e                  state_q, state_d;
  logic [STAB_W-1:0]       stab_cnt_q, stab_cnt_d;
  logic [REL_W-1:0]        rel_cnt_q, rel_cnt_d;
  logic [LOSS_W-1:0]       loss_cnt_q, loss_cnt_d;
  logic [NUM_STAGES-1:0]   stage_rst_n_q, stage_rst_n_d;
  logic                    ready_q, ready_d;
  logic [LOSS_COUNT_W-1:0] loss_count_q, loss_count_d;
  logic [NUM_STAGES-1:0]   stage_due;

  sync_2ff u_lock_sync (
    .clk_i   (clock),
    .rst_n_i (reset_n),
    .d_i     (locked),
    .q_o     (locked_s)
  );

  // Stage k is due in the RELEASE cycle where rel_cnt == k*STAGE_GAP.
  for (genvar gi = 0; gi < NUM_STAGES; gi++) begin : g_stage
    assign stage_due[gi] = (rel_cnt_q == REL_W'(gi * STAGE_GAP));
  end

  always_comb begin
    state_d       = state_q;
    stab_cnt_d    = '0;
    rel_cnt_d     = rel_cnt_q;
    loss_cnt_d    = '0;
    stage_rst_n_d = stage_rst_n_q;
    loss_count_d  = loss_count_q;

    unique case (state_q)
      ST_WAIT_LOCK: begin
        rel_cnt_d = '0;
        if (locked_s) begin
          state_d = ST_STABILIZE;
        end
      end
      ST_STABILIZE: begin
        if (!locked_s) begin
          state_d = ST_WAIT_LOCK;
        end else if (stab_cnt_q == STAB_LAST) begin
          state_d   = ST_RELEASE;
          rel_cnt_d = '0;
        end else begin
          stab_cnt_d = stab_cnt_q + STAB_W'(1);
        end
      end
      ST_RELEASE: begin
        rel_cnt_d     = rel_cnt_q + REL_W'(1);
        stage_rst_n_d = stage_rst_n_q | stage_due;
        if (&stage_rst_n_q) begin
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
      end
      ST_FAULT: begin
        // rel_cnt doubles as the FAULT hold timer.
        if (rel_cnt_q == FAULT_LAST) begin
          state_d   = ST_WAIT_LOCK;
          rel_cnt_d = '0;
        end else begin
          rel_cnt_d = rel_cnt_q + REL_W'(1);
        end
      end
      default: begin
        state_d   = ST_WAIT_LOCK;
        rel_cnt_d = '0;
      end
    endcase

    // Loss filter overrides any stage release in the same cycle.
    if (state_q == ST_RELEASE || state_q == ST_RUN) begin
      if (locked_s) begin
        loss_cnt_d = '0;
      end else if (loss_cnt_q == LOSS_LAST) begin
        state_d       = ST_FAULT;
        stage_rst_n_d = '0;
        rel_cnt_d     = '0;
        loss_count_d  = sat_inc(loss_count_q);
      end else begin
        loss_cnt_d = loss_cnt_q + LOSS_W'(1);
      end
    end

    ready_d = (state_d == ST_RUN);
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= ST_WAIT_LOCK;
      stab_cnt_q    <= '0;
      rel_cnt_q     <= '0;
      loss_cnt_q    <= '0;
      stage_rst_n_q <= '0;
      ready_q       <= 1'b0;
      loss_count_q  <= '0;
    end else begin
      state_q       <= state_d;
      stab_cnt_q    <= stab_cnt_d;
      rel_cnt_q     <= rel_cnt_d;
      loss_cnt_q    <= loss_cnt_d;
      stage_rst_n_q <= stage_rst_n_d;
      ready_q       <= ready_d;
      loss_count_q  <= loss_count_d;
    end
  end

  assign rst_n_out       = stage_rst_n_q;
  assign ready           = ready_q;
  assign lock_loss_count = loss_count_q;
  assign state           = state_q;

endmodule

// File: tb/tb_reset_sequencer.sv
// Scoreboard bench for reset_sequencer: expected output snapshots are queued
// against absolute clock-edge numbers and compared as those edges occur.
`timescale 1ns/1ps
module tb_reset_sequencer;

  logic       clock = 1'b0;
  logic       reset_n = 1'b1;
  logic       locked = 1'b0;
  logic [2:0] rst_n_out;
  logic       ready;
  logic [7:0] lock_loss_count;
  logic [2:0] state;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  typedef struct {
    int         at;
    logic [2:0] rst;
    logic       rdy;
    logic [2:0] st;
    logic [7:0] llc;
    string      tag;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;

  reset_sequencer #(
    .LOCK_STABLE_CYCLES (8),
    .STAGE_GAP          (4),
    .NUM_STAGES         (3),
    .LOSS_FILTER        (4)
  ) dut (
    .clock           (clock),
    .reset_n         (reset_n),
    .locked          (locked),
    .rst_n_out       (rst_n_out),
    .ready           (ready),
    .lock_loss_count (lock_loss_count),
    .state           (state)
  );

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, cycle=%0d required completion", cyc);
    $fatal(1, "watchdog");
  end

  function automatic void push(int at, logic [2:0] r, logic rd, logic [2:0] s, logic [7:0] l, string tag);
    exp_t e;
    e.at = at; e.rst = r; e.rdy = rd; e.st = s; e.llc = l; e.tag = tag;
    sb.push_back(e);
  endfunction

  task automatic wait_until(int target);
    while (cyc < target) @(negedge clock);
  endtask

  task automatic wait_sb(int budget, string tag);
    for (int i = 0; i < budget && sb.size() > 0; i++) @(negedge clock);
    @(negedge clock);
    if (sb.size() > 0) begin
      checks++;
      errors++;
      $display("FAIL %s_timeout: %0d expectations pending, required 0", tag, sb.size());
      sb.delete();
    end
  endtask

  task automatic test_reset();
    reset_n = 1'b1;
    #1 reset_n = 1'b0;
    locked = 1'b0;
    repeat (3) @(negedge clock);
    checks++;
    if ({rst_n_out, ready, state, lock_loss_count} !== 15'd0) begin
      errors++;
      $display("FAIL reset_state: rst=%b ready=%b state=%0d llc=%0d, required all zero",
               rst_n_out, ready, state, lock_loss_count);
    end
    $display("txn reset_state checked");
  endtask

  task automatic test_power_up();
    int b;
    locked  = 1'b1;
    reset_n = 1'b1;
    b = cyc;
    push(b+2,  3'b000, 0, 3'd0, 0, "pu_wait");
    push(b+3,  3'b000, 0, 3'd1, 0, "pu_stab");
    push(b+10, 3'b000, 0, 3'd1, 0, "pu_stab_end");
    push(b+11, 3'b000, 0, 3'd2, 0, "pu_release");
    push(b+12, 3'b001, 0, 3'd2, 0, "pu_stage0");
    push(b+15, 3'b001, 0, 3'd2, 0, "pu_pre_stage1");
    push(b+16, 3'b011, 0, 3'd2, 0, "pu_stage1");
    push(b+19, 3'b011, 0, 3'd2, 0, "pu_pre_stage2");
    push(b+20, 3'b111, 0, 3'd2, 0, "pu_stage2");
    push(b+21, 3'b111, 1, 3'd3, 0, "pu_ready");
    wait_sb(40, "power_up");
  endtask

  task automatic test_glitch_run();
    int b;
    b = cyc;
    locked = 1'b0;
    push(b+5,  3'b111, 1, 3'd3, 0, "gl_first");
    push(b+8,  3'b111, 1, 3'd3, 0, "gl_second");
    push(b+10, 3'b111, 1, 3'd3, 0, "gl_after");
    push(b+14, 3'b111, 1, 3'd3, 0, "gl_settled");
    wait_until(b+3); locked = 1'b1;
    wait_until(b+4); locked = 1'b0;
    wait_until(b+7); locked = 1'b1;
    wait_sb(30, "glitch_run");
  endtask

  task automatic test_lock_loss();
    int b;
    int b2;
    b = cyc;
    locked = 1'b0;
    push(b+5,  3'b111, 1, 3'd3, 0, "ll_pre_fault");
    push(b+6,  3'b000, 0, 3'd4, 1, "ll_fault");
    push(b+9,  3'b000, 0, 3'd4, 1, "ll_fault_last");
    push(b+10, 3'b000, 0, 3'd0, 1, "ll_wait");
    push(b+12, 3'b000, 0, 3'd0, 1, "ll_wait_hold");
    wait_until(b+12);
    locked = 1'b1;
    b2 = cyc;
    push(b2+11, 3'b000, 0, 3'd2, 1, "ll_re_release");
    push(b2+12, 3'b001, 0, 3'd2, 1, "ll_re_stage0");
    push(b2+20, 3'b111, 0, 3'd2, 1, "ll_re_stage2");
    push(b2+21, 3'b111, 1, 3'd3, 1, "ll_re_ready");
    wait_sb(60, "lock_loss");
  endtask

  task automatic test_saturation();
    int b;
    int expv;
    b = cyc;
    locked = 1'b0;
    push(b+6, 3'b000, 0, 3'd4, 2, "sat_first");
    wait_until(b+10);
    for (int i = 0; i < 258; i++) begin
      b = cyc;
      locked = 1'b1;
      expv = (3 + i > 255) ? 255 : 3 + i;
      push(b+17, 3'b000, 0, 3'd4, 8'(expv), "sat_event");
      wait_until(b+11);
      locked = 1'b0;
      wait_until(b+21);
    end
    wait_sb(10, "saturation");
    checks++;
    if (lock_loss_count !== 8'd255) begin
      errors++;
      $display("FAIL sat_hold: llc=%0d, required 255", lock_loss_count);
    end
    $display("txn sat_hold checked llc=%0d", lock_loss_count);
  endtask

  task automatic test_reset_mid_release();
    int b;
    b = cyc;
    locked = 1'b1;
    wait_until(b+13);
    checks++;
    if (rst_n_out !== 3'b001 || state !== 3'd2) begin
      errors++;
      $display("FAIL mid_pre: rst=%b state=%0d, required rst=001 state=2", rst_n_out, state);
    end
    #2 reset_n = 1'b0;
    #1;
    checks++;
    if ({rst_n_out, ready, state, lock_loss_count} !== 15'd0) begin
      errors++;
      $display("FAIL mid_async: rst=%b ready=%b state=%0d llc=%0d, required all zero",
               rst_n_out, ready, state, lock_loss_count);
    end
    $display("txn mid_async checked");
    repeat (2) @(negedge clock);
    reset_n = 1'b1;
    b = cyc;
    push(b+11, 3'b000, 0, 3'd2, 0, "mid_release");
    push(b+12, 3'b001, 0, 3'd2, 0, "mid_stage0");
    push(b+16, 3'b011, 0, 3'd2, 0, "mid_stage1");
    push(b+20, 3'b111, 0, 3'd2, 0, "mid_stage2");
    push(b+21, 3'b111, 1, 3'd3, 0, "mid_ready");
    wait_sb(40, "reset_mid_release");
  endtask

  task automatic test_stabilize_abort();
    int b;
    reset_n = 1'b0;
    repeat (2) @(negedge clock);
    reset_n = 1'b1;
    b = cyc;
    push(b+6,  3'b000, 0, 3'd1, 0, "ab_stab");
    push(b+7,  3'b000, 0, 3'd0, 0, "ab_wait");
    push(b+8,  3'b000, 0, 3'd1, 0, "ab_restab");
    push(b+12, 3'b000, 0, 3'd1, 0, "ab_delayed");
    push(b+16, 3'b000, 0, 3'd2, 0, "ab_release");
    push(b+17, 3'b001, 0, 3'd2, 0, "ab_stage0");
    push(b+26, 3'b111, 1, 3'd3, 0, "ab_ready");
    wait_until(b+4); locked = 1'b0;
    wait_until(b+5); locked = 1'b1;
    wait_sb(40, "stabilize_abort");
  endtask

  initial begin
    fork
      forever begin
        @(negedge clock);
        while (sb.size() > 0 && sb[0].at <= cyc) begin
          mon_e = sb.pop_front();
          checks++;
          if (mon_e.at != cyc ||
              {rst_n_out, ready, state, lock_loss_count} !== {mon_e.rst, mon_e.rdy, mon_e.st, mon_e.llc}) begin
            errors++;
            $display("FAIL %s @edge %0d (now %0d): rst=%b ready=%b state=%0d llc=%0d, required rst=%b ready=%b state=%0d llc=%0d",
                     mon_e.tag, mon_e.at, cyc, rst_n_out, ready, state, lock_loss_count,
                     mon_e.rst, mon_e.rdy, mon_e.st, mon_e.llc);
          end else begin
            $display("txn %s edge %0d rst=%b ready=%b state=%0d llc=%0d",
                     mon_e.tag, cyc, rst_n_out, ready, state, lock_loss_count);
          end
        end
      end
    join_none

    test_reset();
    test_power_up();
    test_glitch_run();
    test_lock_loss();
    test_saturation();
    test_reset_mid_release();
    test_stabilize_abort();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
